// File: rtl/seg7_scroll_mux.sv
// Scrolling 7-segment message display: 17-entry ROM, step prescaler, and digit refresh mux.
// Define SEG7_SCROLL_DIR_EN to honour the dir input; without it the scroll is always forward.
module seg7_scroll_mux #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned TICK_DIV    = 10_000_000,
    parameter int unsigned REFRESH_DIV = 25_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  pause,
    input  logic                  dir,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [4:0]            offset,
    output logic                  wrap
);

    localparam int unsigned MSG_LEN = 17;
    localparam int unsigned PW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REFR_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
    localparam logic [4:0]    OFF_LAST   = 5'(MSG_LEN - 1);

    logic [PW-1:0]         presc;
    logic [RW-1:0]         refr;
    logic [DW-1:0]         dig;
    logic                  step;
    logic                  reverse;
    logic [4:0]            pos;
    logic [4:0]            idx_sum;
    logic [4:0]            idx;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] an_next;

`ifdef SEG7_SCROLL_DIR_EN
    assign reverse = dir;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign reverse    = 1'b0;
`endif

    // Segment patterns are active-low, bit order gfedcba.
    function automatic logic [6:0] msg_rom(input logic [4:0] i);
        logic [6:0] s;
        case (i)
            5'd0:    s = 7'b1111111; // blank
            5'd1:    s = 7'b1000001; // U
            5'd2:    s = 7'b0001000; // A
            5'd3:    s = 7'b0000011; // B
            5'd4:    s = 7'b1000110; // C
            5'd5:    s = 7'b0111111; // -
            5'd6:    s = 7'b0000110; // E
            5'd7:    s = 7'b1000111; // L
            5'd8:    s = 7'b0000110; // E
            5'd9:    s = 7'b1000110; // C
            5'd10:   s = 7'b1001110; // T
            5'd11:   s = 7'b0101111; // R
            5'd12:   s = 7'b1000000; // O
            5'd13:   s = 7'b0101011; // N
            5'd14:   s = 7'b1001111; // I
            5'd15:   s = 7'b1000110; // C
            5'd16:   s = 7'b0001000; // A
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign step = en && !pause && (presc == PRESC_LAST);

    // dig counts down from the leftmost anode, so its screen position is NUM_DIGITS-1-dig.
    always_comb begin
        pos     = 5'(NUM_DIGITS - 1) - 5'(dig);
        idx_sum = offset + pos;
        idx     = (idx_sum >= 5'(MSG_LEN)) ? idx_sum - 5'(MSG_LEN) : idx_sum;
        glyph   = msg_rom(idx);
        an_next = ~(NUM_DIGITS'(1) << dig);
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc  <= '0;
            refr   <= '0;
            dig    <= DIG_LAST;
            offset <= '0;
            wrap   <= 1'b0;
            seg    <= '1;
            an     <= '1;
        end else begin
            wrap <= 1'b0;

            if (!pause) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end

            if (step) begin
                if (reverse) begin
                    if (offset == 5'd0) begin
                        offset <= OFF_LAST;
                        wrap   <= 1'b1;
                    end else begin
                        offset <= offset - 5'd1;
                    end
                end else begin
                    if (offset == OFF_LAST) begin
                        offset <= 5'd0;
                        wrap   <= 1'b1;
                    end else begin
                        offset <= offset + 5'd1;
                    end
                end
            end

            if (refr == REFR_LAST) begin
                refr <= '0;
                dig  <= (dig == '0) ? DIG_LAST : dig - 1'b1;
            end else begin
                refr <= refr + 1'b1;
            end

            seg <= glyph;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scroll_mux.sv
// Directed bench for seg7_scroll_mux with NUM_DIGITS=4, TICK_DIV=4, REFRESH_DIV=2.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_seg7_scroll_mux;

    logic       clk = 1'b0;
    logic       rst, en, pause, dir;
    logic [6:0] seg;
    logic [3:0] an;
    logic [4:0] offset;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    logic [6:0] rom [17];

    typedef struct {
        logic       rst, en, pause, dir;
        logic [4:0] off;
        logic [3:0] an;
        logic [6:0] seg;
        logic       wrap;
    } vec_t;

    vec_t tv [20];

    always #5 clk = ~clk;

    seg7_scroll_mux #(
        .NUM_DIGITS (4),
        .TICK_DIV   (4),
        .REFRESH_DIV(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .pause (pause),
        .dir   (dir),
        .seg   (seg),
        .an    (an),
        .offset(offset),
        .wrap  (wrap)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; pause = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    function automatic int exp_off(input int n, input bit rev);
        int s;
        s = n / 4;
        return rev ? (17 - (s % 17)) % 17 : s % 17;
    endfunction

    // Closed-form expectation for the n-th enabled edge since the counters were cleared.
    task automatic chk_run(input int n, input bit rev, input string tag);
        int d, k, ob, o;
        bit w;
        d  = 3 - (((n - 1) / 2) % 4);
        k  = 3 - d;
        ob = exp_off(n - 1, rev);
        o  = exp_off(n, rev);
        w  = (n % 4 == 0) && (rev ? (o == 16) : (o == 0));
        chk({tag, "_offset"}, int'(offset), o);
        chk({tag, "_wrap"},   int'(wrap),   int'(w));
        chk({tag, "_an"},     int'(an),     int'(~(4'b0001 << d) & 4'hF));
        chk({tag, "_seg"},    int'(seg),    int'(rom[(ob + k) % 17]));
    endtask

    initial begin
        bit rev_eff;
        int wraps;

        rom[0]  = 7'b1111111; rom[1]  = 7'b1000001; rom[2]  = 7'b0001000;
        rom[3]  = 7'b0000011; rom[4]  = 7'b1000110; rom[5]  = 7'b0111111;
        rom[6]  = 7'b0000110; rom[7]  = 7'b1000111; rom[8]  = 7'b0000110;
        rom[9]  = 7'b1000110; rom[10] = 7'b1001110; rom[11] = 7'b0101111;
        rom[12] = 7'b1000000; rom[13] = 7'b0101011; rom[14] = 7'b1001111;
        rom[15] = 7'b1000110; rom[16] = 7'b0001000;

        //            rst   en    pause dir    off    an       seg          wrap
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1111, 7'b1111111, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b1111, 7'b1111111, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'b1111, 7'b1111111, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b0111, 7'b1111111, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b0111, 7'b1111111, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b1011, 7'b1000001, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 4'b1011, 7'b1000001, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 4'b1101, 7'b0000011, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 4'b1101, 7'b0000011, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 4'b1110, 7'b1000110, 1'b0};
        tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 4'b1110, 7'b1000110, 1'b0};
        tv[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 4'b0111, 7'b0001000, 1'b0};
        tv[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 4'b0111, 7'b0001000, 1'b0};
        tv[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 4'b1011, 7'b0000011, 1'b0};
        tv[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 4'b1011, 7'b0000011, 1'b0};
        tv[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 4'b1101, 7'b1000110, 1'b0};
        tv[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 4'b1101, 7'b1000110, 1'b0};
        tv[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 4'b1110, 7'b0111111, 1'b0};
        tv[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 4'b1111, 7'b1111111, 1'b0};
        tv[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b0111, 7'b1111111, 1'b0};

`ifdef SEG7_SCROLL_DIR_EN
        rev_eff = 1'b1;
`else
        rev_eff = 1'b0;
`endif

        rst = 1'b1; en = 1'b0; pause = 1'b0; dir = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            rst = tv[i].rst; en = tv[i].en; pause = tv[i].pause; dir = tv[i].dir;
            tick();
            chk($sformatf("vec%0d_offset", i), int'(offset), int'(tv[i].off));
            chk($sformatf("vec%0d_an", i),     int'(an),     int'(tv[i].an));
            chk($sformatf("vec%0d_seg", i),    int'(seg),    int'(tv[i].seg));
            chk($sformatf("vec%0d_wrap", i),   int'(wrap),   int'(tv[i].wrap));
        end

        // Full forward lap: 17 steps, single wrap on 16->0.
        do_reset();
        dir = 1'b0; en = 1'b1;
        wraps = 0;
        for (int n = 1; n <= 68; n++) begin
            tick();
            if (wrap) wraps++;
            chk_run(n, 1'b0, "fwd");
        end
        chk("fwd_wrap_count", wraps, 1);

        // Reverse from 0 (forward when direction support is compiled out).
        do_reset();
        dir = 1'b1; en = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk_run(n, rev_eff, "dir1");
        end
        dir = 1'b0;

        // Pause at offset 5: position frozen, refresh keeps running.
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk_run(n, 1'b0, "pre_pause");
        end
        pause = 1'b1;
        for (int n = 21; n <= 40; n++) begin
            tick();
            chk("pause_offset", int'(offset), 5);
            chk("pause_wrap",   int'(wrap),   0);
            chk("pause_an",     int'(an), int'(~(4'b0001 << (3 - (((n - 1) / 2) % 4))) & 4'hF));
        end
        pause = 1'b0;
        for (int n = 41; n <= 44; n++) begin
            tick();
            chk("resume_offset", int'(offset), (n == 44) ? 6 : 5);
        end

        // Disable at offset 9, then a reset pulse mid-scroll.
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 36; n++) tick();
        chk("pre_dis_offset", int'(offset), 9);
        en = 1'b0;
        tick();
        chk("dis_offset", int'(offset), 0);
        chk("dis_an",     int'(an),     4'hF);
        chk("dis_seg",    int'(seg),    7'h7F);
        chk("dis_wrap",   int'(wrap),   0);
        en = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            tick();
            chk_run(n, 1'b0, "reen");
        end
        rst = 1'b1;
        tick();
        chk("rstmid_offset", int'(offset), 0);
        chk("rstmid_an",     int'(an),     4'hF);
        chk("rstmid_seg",    int'(seg),    7'h7F);
        chk("rstmid_wrap",   int'(wrap),   0);
        rst = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk_run(n, 1'b0, "post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scroll_mux.md
SEG7_SCROLL_MUX -- requirements
Module: seg7_scroll_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits; legal range 1..8.
REQ-002 Parameter TICK_DIV, default 10_000_000: clk cycles per scroll step; legal minimum 2.
REQ-003 Parameter REFRESH_DIV, default 25_000: clk cycles per digit-refresh slot; legal minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  run enable; 1 = display and scroll, 0 = blank and rewind.
REQ-007 pause  input  1  1 = freeze scroll position, display stays on.
REQ-008 dir  input  1  scroll direction; 0 = forward (offset +1), 1 = reverse (offset -1).
REQ-009 seg  output  7  segment drive, active-low, bit order gfedcba.
REQ-010 an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low when active; an[NUM_DIGITS-1] = leftmost digit.
REQ-011 offset  output  5  current scroll offset, 0..16.
REQ-012 wrap  output  1  one-cycle pulse when offset wraps in either direction.

Function
REQ-013 Message ROM SHALL hold MSG_LEN = 17 fixed entries, index 0..16: blank, U, A, B, C, -, E, L, E, C, T, R, O, N, I, C, A.
REQ-014 Segment codes SHALL be: blank=1111111, U=1000001, A=0001000, B=0000011, C=1000110, -=0111111, E=0000110, L=1000111, T=1001110, R=0101111, O=1000000, N=0101011, I=1001111.
REQ-015 Step prescaler SHALL count 0..TICK_DIV-1 while en=1 and pause=0; step pulse SHALL assert the cycle the count equals TICK_DIV-1, and the count SHALL return to 0 on the next edge.
REQ-016 On step with dir=0, offset SHALL go to offset+1, with 16 -> 0 and wrap=1 on the edge that updates offset.
REQ-017 On step with dir=1, offset SHALL go to offset-1, with 0 -> 16 and wrap=1 on the edge that updates offset.
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1 whenever en=1, independent of pause; at terminal count the digit index SHALL advance from NUM_DIGITS-1 down to 0 and then wrap to NUM_DIGITS-1.
REQ-019 Digit at position k (k=0 leftmost) SHALL show ROM entry (offset+k) mod 17.
REQ-020 seg and an SHALL be registered and SHALL update one clk cycle after the digit index or offset changes.
REQ-021 While en=0, an SHALL be all ones, seg SHALL be 1111111, offset SHALL be 0, both counters SHALL be 0, and wrap SHALL be 0.
REQ-022 en=0 SHALL override pause and dir.
REQ-023 pause=1 SHALL hold the prescaler and offset, and a step SHALL NOT occur in any cycle where pause=1.
REQ-024 A dir change SHALL take effect at the next step, and the prescaler SHALL NOT be reset by a dir change.
REQ-025 On en 0->1, the first step SHALL occur TICK_DIV cycles later, and the leftmost digit SHALL be selected first.

Reset
REQ-026 rst=1 at a clk edge SHALL force an all ones, seg=1111111, offset=0, wrap=0, both counters to 0, and digit index to NUM_DIGITS-1.
REQ-027 rst asserted mid-scroll SHALL discard the position, and after release the behaviour SHALL be as REQ-025 if en=1.
REQ-028 rst SHALL take priority over every other input.

Configuration
REQ-029 Macro SEG7_SCROLL_DIR_EN: when defined, dir SHALL behave per REQ-016/REQ-017.
REQ-030 When SEG7_SCROLL_DIR_EN is undefined, dir SHALL remain a port but be ignored, and scroll SHALL always be forward.

Verification (NUM_DIGITS=4, TICK_DIV=4, REFRESH_DIV=2)
REQ-031 rst=1 for 3 cycles, then en=1 -> offset=0 and first active anode an=0111 with seg=1111111 (blank); after 4 cycles offset=1.
REQ-032 en=1, dir=0, run 68 cycles -> offset steps 0..16 then 0, with exactly one wrap pulse, at the 16->0 edge.
REQ-033 dir=1 from offset 0 -> next step gives offset=16 and wrap=1; leftmost digit shows A=0001000 and next digit shows blank.
REQ-034 pause=1 for 20 cycles at offset 5 -> offset stays 5 and anodes keep cycling 0111, 1011, 1101, 1110.
REQ-035 en 1->0 at offset 9 -> next edge gives an=1111, seg=1111111, offset=0; rst pulse during scroll gives the same result.
REQ-036 Build without SEG7_SCROLL_DIR_EN and drive dir=1 -> offset still increments 0,1,2...
